fcp_mst_seq: RTL and testbench

Parametrised FCP master transaction sequencer sitting above `mst_physical_layer`. It accepts queued 24-bit FCP commands (SBRWR/SBRRD frames), runs each as a ping frame, a programmable quiet gap and a data frame, and then waits for the slave response byte. It retries on CRC/parity error or timeout and returns one status-tagged response per command. Firmware and benches no longer hand-time `pl_tx_en`/`pl_tx_type` sequences.

---
 rtl/fcp_mst_seq.sv | 209 ++++++++++++++++++++
 tb/tb_fcp_mst_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcp_mst_seq.sv
// rtl/fcp_mst_seq.sv - FCP master transaction sequencer above mst_physical_layer
// Queues 24-bit commands, runs ping/gap/data frames, waits for the reply byte and retries on error.
module fcp_mst_seq #(
   parameter int DEPTH       = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int RSP_TIMEOUT = 2048,
   parameter int MAX_RETRY   = 2,
   parameter int CNT_W       = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [23:0]             i_cmd_data,
   input  logic                    i_soft_reset,
   output logic                    o_rsp_valid,
   output logic [7:0]              o_rsp_data,
   output logic [1:0]              o_rsp_status,
   output logic                    o_busy,
   output logic [$clog2(DEPTH):0]  o_fifo_count,
   output logic                    o_pl_tx_en,
   output logic                    o_pl_tx_type,
   output logic                    o_pl_reset,
   output logic [23:0]             o_pl_tx_data,
   input  logic                    i_pl_tx_done,
   input  logic                    i_pl_rx_data_valid,
   input  logic                    i_pl_crc_error,
   input  logic                    i_pl_par_error,
   input  logic [7:0]              i_pl_rx_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(RSP_TIMEOUT - 1);
   localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);
   localparam logic [1:0] ST_OK = 2'b00, ST_ERR = 2'b01, ST_TO = 2'b10, ST_ABORT = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_PING, S_PING_WAIT, S_GAP, S_DATA, S_DATA_WAIT,
      S_RSP_WAIT, S_FAIL, S_GAP_RETRY, S_DONE, S_RESET
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [RW-1:0]    r_retry, w_retry_nxt;
   logic [1:0]       r_code, w_code_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic [23:0]      r_cmd;
   logic [23:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push, w_pop;
   logic             w_tx_en_nxt, w_tx_type_nxt, w_pl_reset_nxt, w_rsp_valid_nxt;
   logic [23:0]      w_tx_data_nxt;
   logic [7:0]       w_rsp_data_nxt;
   logic [1:0]       w_rsp_status_nxt;

   assign o_cmd_ready  = (r_count != FULL_CNT) && (r_state != S_RESET);
   assign o_busy       = (r_state != S_IDLE) || (r_count != '0);
   assign o_fifo_count = r_count;
   assign w_push       = i_cmd_valid && o_cmd_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_retry_nxt      = r_retry;
      w_code_nxt       = r_code;
      w_byte_nxt       = r_byte;
      w_pop            = 1'b0;
      w_tx_en_nxt      = 1'b0;
      w_tx_type_nxt    = 1'b0;
      w_tx_data_nxt    = '0;
      w_pl_reset_nxt   = 1'b0;
      w_rsp_valid_nxt  = 1'b0;
      w_rsp_data_nxt   = r_byte;
      w_rsp_status_nxt = r_code;
      case (r_state)
         S_IDLE: if (r_count != '0) begin
            w_state_nxt = S_PING;
            w_pop       = 1'b1;
            w_retry_nxt = '0;
            w_tx_en_nxt = 1'b1;
         end
         S_PING:      w_state_nxt = S_PING_WAIT;
         S_PING_WAIT: if (i_pl_tx_done) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
         end
         S_GAP: if (r_cnt == GAP_LIM) begin
            w_state_nxt   = S_DATA;
            w_tx_en_nxt   = 1'b1;
            w_tx_type_nxt = 1'b1;
            w_tx_data_nxt = r_cmd;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
         S_DATA:      w_state_nxt = S_DATA_WAIT;
         S_DATA_WAIT: if (i_pl_tx_done) begin
            w_state_nxt = S_RSP_WAIT;
            w_cnt_nxt   = '0;
         end
         // an error pulse outranks a byte arriving in the same cycle
         S_RSP_WAIT: if (i_pl_crc_error || i_pl_par_error) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = ST_ERR;
            w_byte_nxt  = '0;
         end else if (i_pl_rx_data_valid) begin
            w_state_nxt = S_DONE;
            w_code_nxt  = ST_OK;
            w_byte_nxt  = i_pl_rx_data;
         end else if (r_cnt == TO_LIM) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = ST_TO;
            w_byte_nxt  = '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
         S_FAIL: if (r_retry < RETRY_LIM) begin
            w_retry_nxt = r_retry + RW'(1);
            w_state_nxt = S_GAP_RETRY;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = S_DONE;
         end
         S_GAP_RETRY: if (r_cnt == GAP_LIM) begin
            w_state_nxt = S_PING;
            w_tx_en_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
         S_DONE: begin
            w_state_nxt     = S_IDLE;
            w_rsp_valid_nxt = 1'b1;
         end
         S_RESET:     w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
      if (i_soft_reset) begin
         w_state_nxt    = S_RESET;
         w_pop          = 1'b0;
         w_tx_en_nxt    = 1'b0;
         w_tx_type_nxt  = 1'b0;
         w_tx_data_nxt  = '0;
         w_pl_reset_nxt = 1'b1;
         w_rsp_valid_nxt = 1'b0;
         if (r_state != S_IDLE && r_state != S_RESET) begin
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_status_nxt = ST_ABORT;
            w_rsp_data_nxt   = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_cmd_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_soft_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_retry      <= '0;
         r_code       <= ST_OK;
         r_byte       <= '0;
         r_cmd        <= '0;
         o_pl_tx_en   <= 1'b0;
         o_pl_tx_type <= 1'b0;
         o_pl_tx_data <= '0;
         o_pl_reset   <= 1'b0;
         o_rsp_valid  <= 1'b0;
         o_rsp_data   <= '0;
         o_rsp_status <= ST_OK;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_retry      <= w_retry_nxt;
         r_code       <= w_code_nxt;
         r_byte       <= w_byte_nxt;
         if (w_pop) r_cmd <= r_mem[r_rd_ptr];
         o_pl_tx_en   <= w_tx_en_nxt;
         o_pl_tx_type <= w_tx_type_nxt;
         o_pl_tx_data <= w_tx_data_nxt;
         o_pl_reset   <= w_pl_reset_nxt;
         o_rsp_valid  <= w_rsp_valid_nxt;
         if (w_rsp_valid_nxt) begin
            o_rsp_data   <= w_rsp_data_nxt;
            o_rsp_status <= w_rsp_status_nxt;
         end
      end
   end
endmodule

// File: tb/tb_fcp_mst_seq.sv
// tb/tb_fcp_mst_seq.sv - directed self-checking bench for fcp_mst_seq
// A small physical-layer model answers frames from a per-attempt script of reply modes.
module tb_fcp_mst_seq;
   localparam int DEPTH = 4;
   localparam int GAP   = 16;
   localparam int TO    = 2048;
   localparam int MAXR  = 2;

   logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, soft_reset = 1'b0;
   logic [23:0] cmd_data = '0;
   logic        cmd_ready, rsp_valid, busy, pl_tx_en, pl_tx_type, pl_reset;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_status;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [23:0] pl_tx_data;
   logic        pl_tx_done = 1'b0, pl_rx_valid = 1'b0, pl_crc = 1'b0, pl_par = 1'b0;
   logic [7:0]  pl_rx_data = '0;

   int checks = 0, errors = 0, cyc = 0;

   fcp_mst_seq #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .RSP_TIMEOUT(TO), .MAX_RETRY(MAXR), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_data(cmd_data), .i_soft_reset(soft_reset), .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data), .o_rsp_status(rsp_status), .o_busy(busy), .o_fifo_count(fifo_count),
      .o_pl_tx_en(pl_tx_en), .o_pl_tx_type(pl_tx_type), .o_pl_reset(pl_reset),
      .o_pl_tx_data(pl_tx_data), .i_pl_tx_done(pl_tx_done), .i_pl_rx_data_valid(pl_rx_valid),
      .i_pl_crc_error(pl_crc), .i_pl_par_error(pl_par), .i_pl_rx_data(pl_rx_data));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // reply modes: 0 good byte, 1 crc error, 2 parity error, 3 silent
   int          mode_q[$];
   logic [7:0]  byte_q[$];
   logic [23:0] txd_q[$];
   int ping_cnt = 0, data_cnt = 0, ping_cyc = 0, ping_done_cyc = 0, data_cyc = 0, data_done_cyc = 0, rx_cyc = 0;

   initial begin : phy_model
      int         mode;
      logic [7:0] b;
      logic       is_data;
      forever begin
         @(posedge clk); #1;
         if (pl_tx_en) begin
            is_data = pl_tx_type;
            if (is_data) begin data_cnt++; data_cyc = cyc; txd_q.push_back(pl_tx_data); end
            else begin ping_cnt++; ping_cyc = cyc; end
            repeat (2) @(posedge clk);
            #1;
            pl_tx_done = 1'b1;
            if (is_data) data_done_cyc = cyc; else ping_done_cyc = cyc;
            @(posedge clk); #1;
            pl_tx_done = 1'b0;
            if (is_data) begin
               mode = 3;
               b    = '0;
               if (mode_q.size() > 0) begin mode = mode_q.pop_front(); b = byte_q.pop_front(); end
               repeat (3) @(posedge clk);
               #1;
               rx_cyc      = cyc;
               pl_rx_data  = b;
               pl_rx_valid = (mode == 0);
               pl_crc      = (mode == 1);
               pl_par      = (mode == 2);
               @(posedge clk); #1;
               pl_rx_valid = 1'b0;
               pl_crc      = 1'b0;
               pl_par      = 1'b0;
            end
         end
      end
   end

   logic [7:0] rsp_data_q[$];
   logic [1:0] rsp_stat_q[$];
   int         rsp_cyc_q[$];
   int         preset_cnt = 0;

   initial forever begin
      @(posedge clk); #1;
      if (rsp_valid) begin
         rsp_data_q.push_back(rsp_data);
         rsp_stat_q.push_back(rsp_status);
         rsp_cyc_q.push_back(cyc);
      end
      if (pl_reset) preset_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear();
      mode_q.delete(); byte_q.delete(); txd_q.delete();
      rsp_data_q.delete(); rsp_stat_q.delete(); rsp_cyc_q.delete();
      ping_cnt = 0; data_cnt = 0; preset_cnt = 0;
   endtask

   task automatic push(input logic [23:0] d);
      logic acc = 1'b0;
      int   t   = 0;
      cmd_valid = 1'b1;
      cmd_data  = d;
      while (!acc && t < 200) begin
         acc = cmd_ready;
         step(1);
         t++;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!acc) begin errors++; $display("FAIL push_accept: cmd %h not accepted within %0d cycles", d, t); end
   endtask

   task automatic wait_rsp(input int n, input int lim);
      int t = 0;
      while (rsp_data_q.size() < n && t < lim) begin step(1); t++; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      checks++;
      if ({cmd_ready, rsp_valid, busy, pl_tx_en, pl_tx_type, pl_reset} !== 6'b100000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 100000", {cmd_ready, rsp_valid, busy, pl_tx_en, pl_tx_type, pl_reset});
      end
      checks++;
      if ({rsp_data, rsp_status, fifo_count, pl_tx_data} !== '0) begin
         errors++; $display("FAIL reset_data: rsp_data %h status %b count %0d tx_data %h expected all 0", rsp_data, rsp_status, fifo_count, pl_tx_data);
      end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_single();
      int c0;
      clear();
      mode_q.push_back(0); byte_q.push_back(8'h5a);
      c0 = cyc;
      push(24'h000C04);
      wait_rsp(1, 400);
      checks++; if (rsp_data_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rsp_data_q.size()); end
      checks++; if (rsp_data_q[0] !== 8'h5a) begin errors++; $display("FAIL single_data: got %h expected 5a", rsp_data_q[0]); end
      checks++; if (rsp_stat_q[0] !== 2'b00) begin errors++; $display("FAIL single_status: got %b expected 00", rsp_stat_q[0]); end
      checks++; if (txd_q[0] !== 24'h000C04) begin errors++; $display("FAIL single_txdata: got %h expected 000c04", txd_q[0]); end
      checks++; if (ping_cnt != 1 || data_cnt != 1) begin errors++; $display("FAIL single_frames: got %0d/%0d expected 1/1", ping_cnt, data_cnt); end
      checks++; if (ping_cyc - c0 != 2) begin errors++; $display("FAIL single_ping_lat: got %0d expected 2", ping_cyc - c0); end
      checks++; if (data_cyc - ping_done_cyc != GAP + 2) begin errors++; $display("FAIL single_gap_lat: got %0d expected %0d", data_cyc - ping_done_cyc, GAP + 2); end
      checks++; if (rsp_cyc_q[0] - rx_cyc != 2) begin errors++; $display("FAIL single_rsp_lat: got %0d expected 2", rsp_cyc_q[0] - rx_cyc); end
      step(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] cmds [5] = '{24'h0B2C5A, 24'h0B2C78, 24'h0B2C5A, 24'h0B2C32, 24'h0B2C78};
      logic [7:0]  bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      clear();
      for (int i = 0; i < 5; i++) begin mode_q.push_back(0); byte_q.push_back(bytes[i]); end
      for (int i = 0; i < 5; i++) push(cmds[i]);
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d expected 4", fifo_count); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", cmd_ready); end
      cmd_valid = 1'b1;
      cmd_data  = 24'hFFFFFF;
      step(3);
      cmd_valid = 1'b0;
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_no_overwrite: got %0d expected 4", fifo_count); end
      wait_rsp(5, 1500);
      checks++; if (rsp_data_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", rsp_data_q.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_data_q[i] !== bytes[i] || rsp_stat_q[i] !== 2'b00 || txd_q[i] !== cmds[i]) begin
            errors++; $display("FAIL b2b_rsp%0d: got data %h status %b tx %h expected %h 00 %h", i, rsp_data_q[i], rsp_stat_q[i], txd_q[i], bytes[i], cmds[i]);
         end
      end
      step(2);
   endtask

   task automatic test_retry_success();
      clear();
      mode_q.push_back(1); byte_q.push_back(8'h00);
      mode_q.push_back(0); byte_q.push_back(8'h01);
      push(24'h0C2C00);
      wait_rsp(1, 600);
      step(20);
      checks++; if (rsp_data_q.size() != 1) begin errors++; $display("FAIL retry_ok_count: got %0d expected 1", rsp_data_q.size()); end
      checks++; if (rsp_data_q[0] !== 8'h01 || rsp_stat_q[0] !== 2'b00) begin errors++; $display("FAIL retry_ok_rsp: got %h/%b expected 01/00", rsp_data_q[0], rsp_stat_q[0]); end
      checks++; if (ping_cnt != 2 || data_cnt != 2) begin errors++; $display("FAIL retry_ok_frames: got %0d/%0d expected 2/2", ping_cnt, data_cnt); end
   endtask

   task automatic test_retry_exhaust();
      clear();
      for (int i = 0; i < 3; i++) begin mode_q.push_back(2); byte_q.push_back(8'hA5); end
      push(24'h0C1234);
      wait_rsp(1, 800);
      step(20);
      checks++; if (rsp_data_q.size() != 1) begin errors++; $display("FAIL exhaust_count: got %0d expected 1", rsp_data_q.size()); end
      checks++; if (rsp_data_q[0] !== 8'h00 || rsp_stat_q[0] !== 2'b01) begin errors++; $display("FAIL exhaust_rsp: got %h/%b expected 00/01", rsp_data_q[0], rsp_stat_q[0]); end
      checks++; if (ping_cnt != 3 || data_cnt != 3) begin errors++; $display("FAIL exhaust_frames: got %0d/%0d expected 3/3", ping_cnt, data_cnt); end
   endtask

   task automatic test_timeout();
      clear();
      push(24'h0C4400);
      wait_rsp(1, 8000);
      checks++; if (rsp_data_q.size() != 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", rsp_data_q.size()); end
      checks++; if (rsp_data_q[0] !== 8'h00 || rsp_stat_q[0] !== 2'b10) begin errors++; $display("FAIL timeout_rsp: got %h/%b expected 00/10", rsp_data_q[0], rsp_stat_q[0]); end
      checks++; if (ping_cnt != 3) begin errors++; $display("FAIL timeout_pings: got %0d expected 3", ping_cnt); end
      checks++; if (rsp_cyc_q[0] - data_done_cyc != TO + 3) begin errors++; $display("FAIL timeout_lat: got %0d expected %0d", rsp_cyc_q[0] - data_done_cyc, TO + 3); end
      step(2);
   endtask

   task automatic test_soft_reset();
      int t0, t = 0;
      clear();
      t0 = cyc;
      push(24'h0C0101);
      push(24'h0C0202);
      push(24'h0C0303);
      checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL soft_queued: got %0d expected 2", fifo_count); end
      while (ping_done_cyc <= t0 && t < 100) begin step(1); t++; end
      step(5);
      soft_reset = 1'b1;
      step(1);
      soft_reset = 1'b0;
      checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b11, 8'h00}) begin errors++; $display("FAIL soft_abort_rsp: got %b/%b/%h expected 1/11/00", rsp_valid, rsp_status, rsp_data); end
      checks++; if ({pl_reset, cmd_ready, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL soft_reset_state: pl_reset %b ready %b count %0d expected 1 0 0", pl_reset, cmd_ready, fifo_count); end
      step(1);
      checks++; if ({busy, pl_reset, rsp_valid, cmd_ready} !== 4'b0001) begin errors++; $display("FAIL soft_after: busy %b pl_reset %b rsp_valid %b ready %b expected 0 0 0 1", busy, pl_reset, rsp_valid, cmd_ready); end
      step(60);
      checks++; if (rsp_data_q.size() != 1 || preset_cnt != 1 || data_cnt != 0) begin errors++; $display("FAIL soft_quiet: rsps %0d pl_reset cycles %0d data frames %0d expected 1 1 0", rsp_data_q.size(), preset_cnt, data_cnt); end
      clear();
      mode_q.push_back(0); byte_q.push_back(8'h77);
      push(24'h0C0C00);
      wait_rsp(1, 400);
      checks++; if (rsp_data_q.size() != 1 || rsp_data_q[0] !== 8'h77 || rsp_stat_q[0] !== 2'b00) begin errors++; $display("FAIL soft_resume: count %0d data %h status %b expected 1 77 00", rsp_data_q.size(), rsp_data_q[0], rsp_stat_q[0]); end
      checks++; if (txd_q[0] !== 24'h0C0C00) begin errors++; $display("FAIL soft_resume_tx: got %h expected 0c0c00", txd_q[0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_retry_success();
      test_retry_exhaust();
      test_timeout();
      test_soft_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
